// File: rtl/ball_controller.sv
// ball_controller: ball motion, wall/paddle bounces, scoring and serve/play/point/over sequencing
module ball_controller #(
  parameter int STEP_DIV = 131072,
  parameter int BALL_H = 4,
  parameter int P1_X = 20,
  parameter int P2_X = 620,
  parameter int PAUSE_TICKS = 64,
  parameter int WIN_SCORE = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serve,
  input  logic        bat_size,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [1:0]  state,
  output logic        hit,
  output logic        point,
  output logic        game_over
);
  typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;
  localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam int PW = PAUSE_TICKS > 1 ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [10:0] CX = 11'd320;
  localparam logic [10:0] CY = 11'd240;
  state_t st;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic dx, dy, serve_q, press, run, tick, bot, top, ndy, win1, win2, bounce, miss, won;
  logic [10:0] ny;
  logic [11:0] h;
  logic [3:0] s1_inc, s2_inc;
  assign state = st;
  // Step tick, vertical pre-move and paddle window/contact decisions for the current tick
  always_comb begin
    press = serve_q & ~serve;
    run = st == PLAY || st == POINT;
    tick = run && cnt == CW'(STEP_DIV - 1);
    bot = dy && ({1'b0, ball_y} + 12'(BALL_H) >= 12'd479);
    top = !dy && ({1'b0, ball_y} <= 12'(BALL_H));
    ndy = bot ? 1'b0 : top ? 1'b1 : dy;
    ny = ndy ? ball_y + 11'd1 : ball_y - 11'd1;
    h = bat_size ? 12'd40 : 12'd50;
    win1 = ({1'b0, ny} + h + 12'(BALL_H) >= {1'b0, p1_y}) && ({1'b0, ny} <= {1'b0, p1_y} + h + 12'(BALL_H));
    win2 = ({1'b0, ny} + h + 12'(BALL_H) >= {1'b0, p2_y}) && ({1'b0, ny} <= {1'b0, p2_y} + h + 12'(BALL_H));
    bounce = dx ? (ball_x == 11'(P2_X - BALL_H) && win2) : (ball_x == 11'(P1_X + BALL_H) && win1);
    miss = dx ? ball_x == 11'(639 - BALL_H) : ball_x == 11'(BALL_H);
    s1_inc = score1 == 4'd15 ? score1 : score1 + 4'd1;
    s2_inc = score2 == 4'd15 ? score2 : score2 + 4'd1;
    won = score1 == 4'(WIN_SCORE) || score2 == 4'(WIN_SCORE);
  end
  // Game state machine: serve wait, ball motion, post-point pause and game over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= SERVE;
      ball_x <= CX;
      ball_y <= CY;
      dx <= 1'b1;
      dy <= 1'b1;
      score1 <= '0;
      score2 <= '0;
      hit <= 1'b0;
      point <= 1'b0;
      game_over <= 1'b0;
      cnt <= '0;
      pcnt <= '0;
      serve_q <= 1'b1;
    end else begin
      serve_q <= serve;
      hit <= 1'b0;
      point <= 1'b0;
      cnt <= run && !tick ? cnt + 1'b1 : '0;
      case (st)
        SERVE: begin
          ball_x <= CX;
          ball_y <= CY;
          if (press) st <= PLAY;
        end
        PLAY: if (tick) begin
          if (miss) begin
            if (dx) score1 <= s1_inc;
            else score2 <= s2_inc;
            point <= 1'b1;
            st <= POINT;
          end else begin
            ball_y <= ny;
            dy <= ndy;
            dx <= dx ^ bounce;
            hit <= bounce;
            ball_x <= (dx ^ bounce) ? ball_x + 11'd1 : ball_x - 11'd1;
          end
        end
        POINT: if (tick) begin
          if (pcnt == PW'(PAUSE_TICKS - 1)) begin
            pcnt <= '0;
            ball_x <= CX;
            ball_y <= CY;
            st <= won ? OVER : SERVE;
            game_over <= won;
          end else pcnt <= pcnt + 1'b1;
        end
        OVER: begin
          ball_x <= CX;
          ball_y <= CY;
          if (press) begin
            score1 <= '0;
            score2 <= '0;
            game_over <= 1'b0;
            st <= SERVE;
          end
        end
        default: st <= SERVE;
      endcase
    end
  end
endmodule
